// File: rtl/seq_scan_ctrl_if.sv
// Bundle of the upstream handshake, control and result signals of seq_scan_ctrl.
// The master side feeds words; the slave side is the scan controller.
interface seq_scan_ctrl_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clr_total;
  logic        busy;
  logic        done;
  logic [3:0]  word_hits;
  logic [2:0]  first_pos;
  logic        hit_any;
  logic [15:0] total_hits;

  modport master (
    output in_valid, in_data, clr_total,
    input  in_ready, busy, done, word_hits, first_pos, hit_any, total_hits
  );

  modport slave (
    input  in_valid, in_data, clr_total,
    output in_ready, busy, done, word_hits, first_pos, hit_any, total_hits
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Word-serial scan controller: shifts an 8-bit word MSB first through an overlapping
// 1101 detector, reports per-word hit count/first position and keeps a saturating total.
module seq_scan_ctrl #(
  parameter bit CARRY = 1'b1
) (
  input logic         clk,
  input logic         rst,
  seq_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

  function automatic det_state_t det_next(input det_state_t s, input logic b);
    det_state_t n;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S2 : S0;
      S2:      n = b ? S2 : S3;
      S3:      n = b ? S1 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic det_match(input det_state_t s, input logic b);
    return (s == S3) && b;
  endfunction

  ctrl_state_t state;
  det_state_t  det;
  logic [7:0]  data_word;
  logic [2:0]  bit_idx;
  logic [3:0]  word_cnt;
  logic [2:0]  first_idx;
  logic        hit_flag;
  logic [15:0] total_cnt;
  logic        ready_flag;
  logic        busy_flag;
  logic        done_flag;

  logic        cur_bit;
  logic        match;
  det_state_t  det_upd;

  // Current scanned bit, detector successor and match qualified by the SHIFT phase.
  always_comb begin
    cur_bit = data_word[3'd7 - bit_idx];
    det_upd = det_next(det, cur_bit);
    if (state == SHIFT) begin
      match = det_match(det, cur_bit);
    end else begin
      match = 1'b0;
    end
  end

  // Control FSM, detector, per-word results and saturating total with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      det        <= S0;
      data_word  <= 8'h00;
      bit_idx    <= 3'd0;
      word_cnt   <= 4'd0;
      first_idx  <= 3'd0;
      hit_flag   <= 1'b0;
      total_cnt  <= 16'h0000;
      ready_flag <= 1'b1;
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      // Clear beats a coincident match; the total never wraps.
      if (bus.clr_total) begin
        total_cnt <= 16'h0000;
      end else if (match && (total_cnt != 16'hFFFF)) begin
        total_cnt <= total_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_word  <= bus.in_data;
            bit_idx    <= 3'd0;
            word_cnt   <= 4'd0;
            first_idx  <= 3'd0;
            hit_flag   <= 1'b0;
            if (CARRY == 1'b0) begin
              det <= S0;
            end
            state      <= SHIFT;
            ready_flag <= 1'b0;
            busy_flag  <= 1'b1;
          end
        end
        SHIFT: begin
          det     <= det_upd;
          bit_idx <= bit_idx + 3'd1;
          if (match) begin
            word_cnt <= word_cnt + 4'd1;
            hit_flag <= 1'b1;
            if (word_cnt == 4'd0) begin
              first_idx <= bit_idx;
            end
          end
          if (bit_idx == 3'd7) begin
            state     <= REPORT;
            done_flag <= 1'b1;
          end
        end
        REPORT: begin
          state      <= IDLE;
          done_flag  <= 1'b0;
          busy_flag  <= 1'b0;
          ready_flag <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          done_flag  <= 1'b0;
          busy_flag  <= 1'b0;
          ready_flag <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_flag;
  assign bus.busy       = busy_flag;
  assign bus.done       = done_flag;
  assign bus.word_hits  = word_cnt;
  assign bus.first_pos  = first_idx;
  assign bus.hit_any    = hit_flag;
  assign bus.total_hits = total_cnt;

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter: CARRY, default 1, meaning 1 = pattern-detector state persists across words, 0 = detector cleared at each word accept.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  8  word to scan, MSB first.
REQ-006 in_ready  output  1  controller can accept a word this cycle.
REQ-007 clr_total  input  1  synchronous clear of total_hits.
REQ-008 busy  output  1  high while a word is being scanned or reported.
REQ-009 done  output  1  one-cycle pulse; the outputs word_hits, first_pos and hit_any are valid when it is high.
REQ-010 word_hits  output  4  number of 1101 matches completed within the last word.
REQ-011 first_pos  output  3  bit index (0 = MSB) at which the first match of the last word completed; 0 if none.
REQ-012 hit_any  output  1  word_hits != 0 for the last word.
REQ-013 total_hits  output  16  saturating running count of all matches since reset/clear.

Function
REQ-014 The controller SHALL contain one embedded overlapping Mealy 1101 detector with states S0 (""), S1 ("1"), S2 ("11") and S3 ("110"); its transitions SHALL be S0 -1-> S1, S1 -1-> S2, S1 -0-> S0, S2 -1-> S2, S2 -0-> S3, S3 -1-> S1 with a match, and every other input SHALL return to S0.
REQ-015 The control FSM SHALL have the states IDLE, SHIFT and REPORT.
REQ-016 In IDLE, in_ready SHALL be 1 and busy 0; on in_valid&&in_ready the FSM SHALL latch in_data, zero bit_idx, word_hits and first_pos, and go to SHIFT.
REQ-017 In SHIFT, on each cycle the FSM SHALL feed bit in_data[7-bit_idx] to the detector, and then increment bit_idx; in_ready SHALL be 0 and busy 1.
REQ-018 When a match occurs in SHIFT, word_hits SHALL increment, first_pos SHALL capture bit_idx if it is the first match of the word, and total_hits SHALL increment, saturating at 16'hFFFF.
REQ-019 After bit_idx 7 is processed, the FSM SHALL go to REPORT; REPORT SHALL last exactly 1 cycle with done=1, busy=1 and in_ready=0, then return to IDLE.
REQ-020 Timing: for an accept at edge T, bits SHALL be processed on cycles T+1..T+8, done SHALL be high in cycle T+9, and in_ready SHALL be high again in cycle T+10; the maximum throughput SHALL be 1 word per 10 cycles.
REQ-021 word_hits, first_pos and hit_any SHALL hold their values after done until the next accept.
REQ-022 CARRY=1: the detector state SHALL persist across word boundaries and idle gaps.
REQ-023 CARRY=0: the detector state SHALL be forced to S0 at accept.
REQ-024 The detector SHALL NOT advance in IDLE or REPORT.
REQ-025 in_valid while not ready SHALL be ignored, and in_data SHALL NOT be sampled.
REQ-026 clr_total SHALL zero total_hits on the next edge; a match in the same cycle as clr_total SHALL be lost, and clear SHALL win.
REQ-027 total_hits at 16'hFFFF SHALL stay 16'hFFFF on further matches.

Reset
REQ-028 When rst is high, the next edge SHALL put the FSM in IDLE and the detector in S0, set bit_idx=0, set word_hits=0, first_pos=0, hit_any=0, total_hits=0 and done=0, set busy=0, and set in_ready=1 from the following cycle.
REQ-029 rst SHALL take priority over in_valid and clr_total.
REQ-030 Reset mid-SHIFT or in REPORT SHALL abort the word with no done pulse.

Verification
REQ-031 Accept 0xD0 (CARRY=1, fresh reset) -> done at T+9, word_hits=1, first_pos=3, hit_any=1, total_hits=1.
REQ-032 Accept 0x6D -> word_hits=2 (at idx4 and idx7, overlap), first_pos=4; then accept 0xDB -> word_hits=2, first_pos=3, total_hits=4.
REQ-033 CARRY=1: accept 0x06 then 0x80 -> 2nd word word_hits=1, first_pos=0; CARRY=0 same stimulus -> 2nd word word_hits=0, hit_any=0.
REQ-034 Hold in_valid=1 continuously with changing data -> accepts occur only in the IDLE cycles (every 10 cycles), and in_data changes during SHIFT do not alter the results.
REQ-035 Assert rst in the 5th SHIFT cycle -> no done pulse, in_ready=1 after reset, total_hits=0, and the next word 0xD0 gives word_hits=1.
REQ-036 Feed 32768 words of 0xDB -> total_hits=16'hFFFF (saturated); then pulse clr_total -> total_hits=0.
